// File: rtl/global_pkg.sv
// Shared types and constants for the memory access path.
// Holds request/state enums, funct3 codes and a legality helper.
package global_pkg;

   typedef enum logic [1:0] {
      MEM_NONE,
      FETCH_DATA,
      LOAD_DATA,
      STORE_DATA
   } memory_operation_t;

   typedef enum logic [1:0] {
      IDLE,
      ACCEPT,
      BUS,
      RESP
   } mau_state_t;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   // Stores only have byte/half/word; loads add the unsigned forms.
   function automatic logic f3_legal(
      input memory_operation_t op,
      input logic [2:0]        f3
   );
      if (op == STORE_DATA)
         return (f3 == SB) || (f3 == SH) || (f3 == SW);
      return (f3 == LB) || (f3 == LH) || (f3 == LW) ||
             (f3 == LBU) || (f3 == LHU);
   endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Byte-lane steering for stores and extraction/extension for loads.
// Purely combinational; also flags width-misaligned addresses.
module byte_lane_align
   import global_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr,
   input  logic [31:0] i_store_data,
   input  logic [31:0] i_wb_dat,
   output logic [3:0]  o_sel,
   output logic [31:0] o_wdat,
   output logic [31:0] o_ldata,
   output logic        o_misaligned
);

   logic [31:0] w_sh;

   // Decode access width into lanes, replicated data and extension.
   always_comb begin
      w_sh         = i_wb_dat >> {i_addr, 3'b000};
      o_sel        = 4'b0000;
      o_wdat       = 32'h0;
      o_ldata      = w_sh;
      o_misaligned = 1'b0;
      case (i_funct3[1:0])
         2'b00: begin
            o_sel   = 4'b0001 << i_addr;
            o_wdat  = {4{i_store_data[7:0]}};
            o_ldata = i_funct3[2] ? {24'h0, w_sh[7:0]}
                                  : {{24{w_sh[7]}}, w_sh[7:0]};
         end
         2'b01: begin
            o_sel        = 4'b0011 << i_addr;
            o_wdat       = {2{i_store_data[15:0]}};
            o_ldata      = i_funct3[2] ? {16'h0, w_sh[15:0]}
                                       : {{16{w_sh[15]}}, w_sh[15:0]};
            o_misaligned = i_addr[0];
         end
         2'b10: begin
            o_sel        = 4'b1111;
            o_wdat       = i_store_data;
            o_ldata      = w_sh;
            o_misaligned = |i_addr;
         end
         default: begin
            o_misaligned = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/memory_access_unit.sv
// Turns control-unit memory requests into single Wishbone cycles.
// Misaligned/illegal requests and stalled slaves end in an err pulse.
module memory_access_unit
   import global_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
)(
   input  logic              clk,
   input  logic              rst,
   input  memory_operation_t memory_operation,
   input  logic              cyc,
   input  logic [2:0]        funct3,
   input  logic [31:0]       pc,
   input  logic [31:0]       ls_addr,
   input  logic [31:0]       store_data,
   output logic              ack,
   output logic              data_valid,
   output logic              done,
   output logic              err,
   output logic [31:0]       fetched_data,
   output logic [31:0]       load_data,
   output logic [31:0]       wb_adr_o,
   output logic [31:0]       wb_dat_o,
   input  logic [31:0]       wb_dat_i,
   output logic [3:0]        wb_sel_o,
   output logic              wb_we_o,
   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   input  logic              wb_ack_i,
   input  logic              wb_err_i
);

   localparam logic [15:0] LP_LAST = 16'(TIMEOUT_CYCLES - 1);

   mau_state_t        r_state;
   mau_state_t        w_next;
   memory_operation_t r_op;
   logic [2:0]        r_f3;
   logic [31:0]       r_addr;
   logic [31:0]       r_sdata;
   logic              r_err;
   logic [15:0]       r_cnt;
   logic [31:0]       r_fetched;
   logic [31:0]       r_load;

   logic [3:0]        w_sel;
   logic [31:0]       w_wdat;
   logic [31:0]       w_ldata;
   logic              w_mis;
   logic              w_bad;
   logic              w_tmo;
   logic              w_bus;
   logic              w_req;

   byte_lane_align u_align (
      .i_funct3     (r_f3),
      .i_addr       (r_addr[1:0]),
      .i_store_data (r_sdata),
      .i_wb_dat     (wb_dat_i),
      .o_sel        (w_sel),
      .o_wdat       (w_wdat),
      .o_ldata      (w_ldata),
      .o_misaligned (w_mis)
   );

   assign w_req = cyc && (memory_operation != MEM_NONE);
   assign w_bad = w_mis || !f3_legal(r_op, r_f3);
   assign w_tmo = (r_cnt == LP_LAST);
   assign w_bus = (r_state == BUS);

   // Next-state selection for the request lifecycle.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:   if (w_req) w_next = ACCEPT;
         ACCEPT: w_next = w_bad ? RESP : BUS;
         BUS:    if (wb_ack_i || wb_err_i || w_tmo) w_next = RESP;
         RESP:   w_next = IDLE;
      endcase
   end

   // State, request latch, timeout counter and result capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_op      <= MEM_NONE;
         r_f3      <= 3'b000;
         r_addr    <= 32'h0;
         r_sdata   <= 32'h0;
         r_err     <= 1'b0;
         r_cnt     <= 16'h0;
         r_fetched <= 32'h0;
         r_load    <= 32'h0;
      end else begin
         r_state <= w_next;
         unique case (r_state)
            IDLE: begin
               if (w_req) begin
                  r_op    <= memory_operation;
                  r_f3    <= (memory_operation == FETCH_DATA) ? LW : funct3;
                  r_addr  <= (memory_operation == FETCH_DATA) ? pc : ls_addr;
                  r_sdata <= store_data;
                  r_err   <= 1'b0;
                  r_cnt   <= 16'h0;
               end
            end
            ACCEPT: begin
               if (w_bad) r_err <= 1'b1;
            end
            BUS: begin
               r_cnt <= r_cnt + 16'd1;
               if (wb_ack_i) begin
                  if (r_op == FETCH_DATA) r_fetched <= wb_dat_i;
                  else if (r_op == LOAD_DATA) r_load <= w_ldata;
               end else if (wb_err_i || w_tmo) begin
                  r_err <= 1'b1;
               end
            end
            RESP: begin
               r_cnt <= 16'h0;
            end
         endcase
      end
   end

   // Handshake pulses decode from state; bus signals only live in BUS.
   always_comb begin
      ack          = (r_state == ACCEPT);
      err          = (r_state == RESP) && r_err;
      data_valid   = (r_state == RESP) && !r_err && (r_op != STORE_DATA);
      done         = (r_state == RESP) && !r_err && (r_op == STORE_DATA);
      fetched_data = r_fetched;
      load_data    = r_load;
      wb_cyc_o     = w_bus;
      wb_stb_o     = w_bus;
      wb_we_o      = w_bus && (r_op == STORE_DATA);
      wb_adr_o     = w_bus ? {r_addr[31:2], 2'b00} : 32'h0;
      wb_sel_o     = w_bus ? w_sel : 4'b0000;
      wb_dat_o     = w_bus ? w_wdat : 32'h0;
   end

endmodule

// File: tb/tb_memory_access_unit.sv
// Scoreboard bench: stimulus pushes expected responses, monitor pops them.
// A small behavioural Wishbone slave answers in the BUS cycle.
module tb_memory_access_unit;
   import global_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   memory_operation_t memory_operation;
   logic              cyc;
   logic [2:0]        funct3;
   logic [31:0]       pc, ls_addr, store_data;
   logic              ack, data_valid, done, err;
   logic [31:0]       fetched_data, load_data;
   logic [31:0]       wb_adr_o, wb_dat_o, wb_dat_i;
   logic [3:0]        wb_sel_o;
   logic              wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;

   typedef struct {
      logic [2:0]  kind;
      bit          fetch;
      bit          chk;
      logic [31:0] val;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   s_mode = 0;
   logic [31:0] s_rdata = 32'h0;
   bit   s_force = 1'b0;

   localparam logic [2:0] K_DV  = 3'b001;
   localparam logic [2:0] K_DN  = 3'b010;
   localparam logic [2:0] K_ER  = 3'b100;

   memory_access_unit #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst),
      .memory_operation(memory_operation), .cyc(cyc),
      .funct3(funct3), .pc(pc), .ls_addr(ls_addr),
      .store_data(store_data),
      .ack(ack), .data_valid(data_valid), .done(done), .err(err),
      .fetched_data(fetched_data), .load_data(load_data),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
      .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
      .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Slave: mode 0 ack, 1 err, 2 silent, 3 ack+err together.
   initial begin
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = 32'h0;
      forever begin
         @(negedge clk);
         wb_ack_i = s_force ||
                    (wb_cyc_o && wb_stb_o && (s_mode == 0 || s_mode == 3));
         wb_err_i = wb_cyc_o && wb_stb_o && (s_mode == 1 || s_mode == 3);
         wb_dat_i = s_rdata;
      end
   end

   // Monitor: every response pulse must match the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (data_valid || done || err) begin
            if (q.size() == 0) begin
               chk("unexpected_resp", {29'h0, err, done, data_valid}, 32'h0);
            end else begin
               e = q.pop_front();
               chk("resp_kind", {29'h0, err, done, data_valid},
                   {29'h0, e.kind});
               if (e.chk)
                  chk(e.fetch ? "fetched_data" : "load_data",
                      e.fetch ? fetched_data : load_data, e.val);
            end
         end
      end
   end

   task automatic push(input logic [2:0] k, input bit f, input bit c,
                       input logic [31:0] v);
      exp_t e;
      e.kind = k; e.fetch = f; e.chk = c; e.val = v;
      q.push_back(e);
   endtask

   task automatic req(input memory_operation_t op, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] sd);
      @(negedge clk);
      memory_operation = op;
      funct3 = f3; pc = a; ls_addr = a; store_data = sd; cyc = 1'b1;
      @(posedge clk); #1;
      chk("ack_pulse", {31'h0, ack}, 32'h1);
      cyc = 1'b0;
      memory_operation = MEM_NONE;
   endtask

   task automatic run(input memory_operation_t op, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] sd,
                      input logic [31:0] rd, input int mode, input bit bus,
                      input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat);
      s_mode = mode;
      s_rdata = rd;
      req(op, f3, a, sd);
      @(posedge clk); #1;
      chk("ack_one_cycle", {31'h0, ack}, 32'h0);
      chk("wb_cyc", {31'h0, wb_cyc_o}, {31'h0, bus});
      if (bus) begin
         chk("wb_adr", wb_adr_o, adr);
         chk("wb_sel", {28'h0, wb_sel_o}, {28'h0, sel});
         chk("wb_we", {31'h0, wb_we_o}, {31'h0, op == STORE_DATA});
         if (op == STORE_DATA) chk("wb_dat", wb_dat_o, dat);
      end else begin
         chk("err_after_ack", {31'h0, err}, 32'h1);
      end
      repeat (3) @(posedge clk);
   endtask

   initial begin
      int n;
      rst = 1'b1; cyc = 1'b0; memory_operation = MEM_NONE;
      funct3 = 3'b000; pc = 32'h0; ls_addr = 32'h0; store_data = 32'h0;
      repeat (2) @(posedge clk); #1;
      chk("rst_outs", {27'h0, wb_cyc_o, ack, data_valid, done, err}, 32'h0);
      chk("rst_data", fetched_data | load_data | wb_adr_o | wb_dat_o, 32'h0);
      chk("rst_sel_we", {27'h0, wb_sel_o, wb_we_o}, 32'h0);
      @(negedge clk); rst = 1'b0;

      push(K_DV, 1, 1, 32'h00500093);
      run(FETCH_DATA, 3'b111, 32'h10, 32'h0, 32'h00500093, 0, 1,
          32'h10, 4'hF, 32'h0);
      push(K_DV, 0, 1, 32'hFFFFFF80);
      run(LOAD_DATA, LB, 32'h103, 32'h0, 32'h80FF7F01, 0, 1,
          32'h100, 4'h8, 32'h0);
      push(K_DV, 0, 1, 32'h00000080);
      run(LOAD_DATA, LBU, 32'h103, 32'h0, 32'h80FF7F01, 0, 1,
          32'h100, 4'h8, 32'h0);
      push(K_DN, 0, 0, 32'h0);
      run(STORE_DATA, SH, 32'h22, 32'h1234ABCD, 32'h0, 0, 1,
          32'h20, 4'hC, 32'hABCDABCD);
      push(K_ER, 0, 1, 32'h00000080);
      run(LOAD_DATA, LW, 32'h41, 32'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0);
      push(K_DV, 0, 1, 32'hFFFF80FF);
      run(LOAD_DATA, LH, 32'h102, 32'h0, 32'h80FF7F01, 0, 1,
          32'h100, 4'hC, 32'h0);
      push(K_DV, 0, 1, 32'h000080FF);
      run(LOAD_DATA, LHU, 32'h102, 32'h0, 32'h80FF7F01, 0, 1,
          32'h100, 4'hC, 32'h0);
      push(K_DV, 0, 1, 32'hDEADBEEF);
      run(LOAD_DATA, LW, 32'h104, 32'h0, 32'hDEADBEEF, 0, 1,
          32'h104, 4'hF, 32'h0);
      push(K_DN, 0, 0, 32'h0);
      run(STORE_DATA, SB, 32'h101, 32'h00000055, 32'h0, 0, 1,
          32'h100, 4'h2, 32'h55555555);
      push(K_DN, 0, 0, 32'h0);
      run(STORE_DATA, SW, 32'h200, 32'hCAFEF00D, 32'h0, 0, 1,
          32'h200, 4'hF, 32'hCAFEF00D);
      push(K_ER, 0, 1, 32'hDEADBEEF);
      run(LOAD_DATA, 3'b011, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0);
      push(K_ER, 0, 0, 32'h0);
      run(STORE_DATA, 3'b100, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0);
      push(K_ER, 0, 1, 32'hDEADBEEF);
      run(LOAD_DATA, LW, 32'h108, 32'h0, 32'h11111111, 1, 1,
          32'h108, 4'hF, 32'h0);
      push(K_DV, 0, 1, 32'h0BADF00D);
      run(LOAD_DATA, LW, 32'h108, 32'h0, 32'h0BADF00D, 3, 1,
          32'h108, 4'hF, 32'h0);

      // Silent slave: bus held for the timeout window, then err.
      s_mode = 2;
      push(K_ER, 0, 1, 32'h0BADF00D);
      req(LOAD_DATA, LW, 32'h300, 32'h0);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (wb_cyc_o) n++;
      end
      chk("timeout_cycles", n, 32'd8);
      push(K_DV, 1, 1, 32'h00000013);
      run(FETCH_DATA, LW, 32'h44, 32'h0, 32'h00000013, 0, 1,
          32'h44, 4'hF, 32'h0);

      // Reset while the bus cycle is open; a late ack is ignored.
      s_mode = 2;
      req(LOAD_DATA, LW, 32'h400, 32'h0);
      @(posedge clk); #1;
      chk("bus_before_rst", {31'h0, wb_cyc_o}, 32'h1);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_drops_cyc", {31'h0, wb_cyc_o}, 32'h0);
      @(negedge clk); rst = 1'b0; s_mode = 0; s_force = 1'b1;
      repeat (2) @(negedge clk);
      s_force = 1'b0;
      repeat (4) @(posedge clk); #1;
      chk("post_rst_outs", {27'h0, wb_cyc_o, ack, data_valid, done, err},
          32'h0);
      chk("post_rst_data", fetched_data | load_data, 32'h0);
      chk("queue_drained", q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/memory_access_unit.md
Name: memory_access_unit

Overview:
Sits directly downstream of the control unit and executes its memory requests: instruction fetch, load and store. Each request is translated into one Wishbone-classic single-beat bus cycle, with byte-lane steering and load sign/zero extension. Returns the control-unit handshake signals (ack, data_valid, done, err). Misaligned accesses and bus timeouts are reported as err without hanging the core.

Parameters:
TIMEOUT_CYCLES, 255, number of BUS cycles without wb_ack_i/wb_err_i before an err is reported (1..65535).

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous active-high reset
memory_operation  input  memory_operation_t  MEM_NONE / FETCH_DATA / LOAD_DATA / STORE_DATA
cyc  input  1  request valid from control unit
funct3  input  3  access width/sign (IR[14:12]; LW for fetch)
pc  input  32  fetch address
ls_addr  input  32  load/store effective address
store_data  input  32  rs2 value for stores
ack  output  1  one-cycle pulse: request accepted
data_valid  output  1  one-cycle pulse: fetched_data/load_data valid
done  output  1  one-cycle pulse: store completed
err  output  1  one-cycle pulse: misaligned, bus error or timeout
fetched_data  output  32  last fetched instruction word
load_data  output  32  last load result, extended to 32 bits
wb_adr_o  output  32  bus address, word aligned ({addr[31:2],2'b00})
wb_dat_o  output  32  lane-shifted store data
wb_dat_i  input  32  bus read data
wb_sel_o  output  4  byte enables
wb_we_o  output  1  write enable
wb_cyc_o  output  1  bus cycle
wb_stb_o  output  1  strobe
wb_ack_i  input  1  bus acknowledge
wb_err_i  input  1  bus error

Behaviour:
- Reset (synchronous, rst high at posedge):
  - state=IDLE.
  - ack, data_valid, done, err, wb_cyc_o, wb_stb_o, wb_we_o = 0.
  - wb_sel_o=0, wb_adr_o=0, wb_dat_o=0, fetched_data=0, load_data=0, timeout counter=0.
  - Reset mid-transaction drops wb_cyc_o/wb_stb_o in the same cycle; any late wb_ack_i is ignored.
- States: IDLE, ACCEPT, BUS, RESP.
- IDLE:
  - If cyc=1 and memory_operation!=MEM_NONE: latch op, funct3, address (pc for FETCH_DATA, else ls_addr) and store_data; go to ACCEPT.
  - cyc with MEM_NONE is ignored.
- ACCEPT:
  - ack=1 for exactly this cycle.
  - Misalignment check on the latched address: word (fetch, LW, SW) needs addr[1:0]=00; half (LH, LHU, SH) needs addr[0]=0; bytes are never misaligned.
  - Misaligned: go to RESP with error flag set; no bus cycle is issued.
  - Aligned: go to BUS.
- BUS:
  - wb_cyc_o=wb_stb_o=1; adr/sel/we/dat held stable; timeout counter increments each cycle.
  - wb_ack_i=1: capture result, go to RESP. wb_ack_i has priority if wb_ack_i and wb_err_i are both high.
  - wb_err_i=1: error flag set, go to RESP.
  - Counter reaches TIMEOUT_CYCLES: error flag set, go to RESP.
  - wb_cyc_o/wb_stb_o drop on the cycle after ack/err/timeout.
- RESP:
  - Exactly one of err, data_valid (fetch/load) or done (store) pulses for one cycle; then go to IDLE.
  - Counter cleared.
  - On err, fetched_data/load_data keep their previous values.
- Latency, aligned access with a zero-wait-state slave: cyc seen at edge 0 → ack at edge 1 → BUS at edge 2, wb_ack_i in the same cycle → data_valid/done at edge 3.
- Requests arriving outside IDLE are ignored. The control unit drops cyc after seeing ack, so no double accept occurs.
- Store lanes:
  - SB (000): sel=0001<<addr[1:0], data replicated in all byte lanes.
  - SH (001): sel=0011<<addr[1:0], half replicated.
  - SW (010): sel=1111.
- Load extract: byte/half selected by addr[1:0].
  - LB 000 sign-extend, LBU 100 zero-extend.
  - LH 001 sign-extend, LHU 101 zero-extend.
  - LW 010 pass through.
  - Fetch always uses sel=1111, word.
- Undefined funct3 (011, 110, 111) on load/store: err, no bus cycle.

Decomposition:
- global_pkg additions:
  - mau_state_t {IDLE, ACCEPT, BUS, RESP}.
  - Width constants LB, LH, LW, LBU, LHU, SB, SH, SW.
  - memory_operation_t is reused unchanged.
- One combinational sub-module, byte_lane_align: inputs funct3, addr[1:0], store_data, wb_dat_i; outputs wb_sel, shifted store data, extended load data, misaligned flag.

Test Plan:
- Fetch pc=0x00000010, slave returns 0x00500093 with 0 wait states → ack at edge 1, wb_adr_o=0x10, sel=1111, data_valid at edge 3, fetched_data=0x00500093.
- LB at ls_addr=0x103, wb_dat_i=0x80FF7F01 → sel=1000, load_data=0xFFFFFF80; LBU, same stimulus → load_data=0x00000080.
- SH at ls_addr=0x22, store_data=0x1234ABCD → wb_adr_o=0x20, sel=1100, we=1, wb_dat_o=0xABCDABCD, done pulse, no data_valid.
- LW at ls_addr=0x41 → ack, then err one cycle later, wb_cyc_o never asserted, load_data unchanged.
- Load with slave never acking, TIMEOUT_CYCLES=8 → wb_cyc_o high 8 cycles, then err pulse, return to IDLE; a following fetch completes normally.
- rst asserted during BUS, slave acks afterwards → wb_cyc_o=0 the next cycle, no data_valid/done/err, all outputs at reset values.
